// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: per-frame character width, parity and stop length.
// Paced by an external s_tick oversampling strobe (S ticks per bit); all outputs registered.
module uart_tx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int S        = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             s_tick,
  input  logic                             start,
  input  logic [DBIT_MAX-1:0]              d_in,
  input  logic [$clog2(DBIT_MAX+1)-1:0]    dbits,
  input  logic [1:0]                       par_mode,
  input  logic [1:0]                       stop_mode,
  output logic                             tx,
  output logic                             busy,
  output logic                             done_tick
);

  localparam int DBW = $clog2(DBIT_MAX + 1);
  localparam int CW  = $clog2(2 * S);

  localparam logic [DBW-1:0] DMAX     = DBW'(DBIT_MAX);
  localparam logic [DBW-1:0] ONE_B    = DBW'(1);
  localparam logic [CW-1:0]  S_LAST   = CW'(S - 1);
  localparam logic [CW-1:0]  S15_LAST = CW'(S + S / 2 - 1);
  localparam logic [CW-1:0]  S2_LAST  = CW'(2 * S - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  logic [CW-1:0]         tick_q;
  logic [DBW-1:0]        bit_q;
  logic [DBW-1:0]        dlast_q;
  logic [DBIT_MAX-1:0]   sh_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic [1:0]            stop_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DBW-1:0]        eff_dbits_d;
  logic [CW-1:0]         sb_last_d;

  // Parity over the low n bits only; odd parity is the inverted XOR.
  function automatic logic parity_f(input logic [DBIT_MAX-1:0] d,
                                    input logic [DBW-1:0]      n,
                                    input logic                odd);
    logic p;
    p = odd;
    for (int i = 0; i < DBIT_MAX; i++) begin
      if (DBW'(i) < n) p = p ^ d[i];
    end
    return p;
  endfunction

  always_comb begin
    eff_dbits_d = dbits;
    if (dbits == '0 || dbits > DMAX) eff_dbits_d = DMAX;
  end

  always_comb begin
    sb_last_d = S_LAST;
    case (stop_q)
      2'b01:   sb_last_d = S15_LAST;
      2'b10:   sb_last_d = S2_LAST;
      default: sb_last_d = S_LAST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      dlast_q   <= '0;
      sh_q      <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (start) begin
            sh_q      <= d_in;
            dlast_q   <= eff_dbits_d - ONE_B;
            par_en_q  <= par_mode[0] ^ par_mode[1];
            par_bit_q <= parity_f(d_in, eff_dbits_d, par_mode[1]);
            stop_q    <= stop_mode;
            tick_q    <= '0;
            bit_q     <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: if (s_tick) begin
          if (tick_q == S_LAST) begin
            tick_q  <= '0;
            tx_q    <= sh_q[0];
            state_q <= DATA;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        DATA: if (s_tick) begin
          if (tick_q == S_LAST) begin
            tick_q <= '0;
            sh_q   <= sh_q >> 1;
            if (bit_q == dlast_q) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= sh_q[1];
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        PARITY: if (s_tick) begin
          if (tick_q == S_LAST) begin
            tick_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        STOP: if (s_tick) begin
          if (tick_q == sb_last_d) begin
            tick_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected per-bit line levels are queued at start
// and compared against the tx level observed on every s_tick of the frame.
module tb_uart_tx_cfg;

  localparam int S = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       start;
  logic [7:0] d_in;
  logic [3:0] dbits;
  logic [1:0] par_mode;
  logic [1:0] stop_mode;
  logic       tx;
  logic       busy;
  logic       done_tick;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic val;
    int   len;
    bit   last;
  } seg_t;

  seg_t exp_q[$];

  uart_tx_cfg #(.DBIT_MAX(8), .S(S)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_tick    (s_tick),
    .start     (start),
    .d_in      (d_in),
    .dbits     (dbits),
    .par_mode  (par_mode),
    .stop_mode (stop_mode),
    .tx        (tx),
    .busy      (busy),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;

  // One-clk-wide tick every other clock, changed away from both clock edges.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      s_tick = ~s_tick;
    end
  end

  task automatic push_frame(input logic [7:0] d, input int nb, input int pm, input int sm);
    int   eff;
    int   sb;
    logic p;
    eff = (nb == 0 || nb > 8) ? 8 : nb;
    exp_q.push_back('{1'b0, S, 1'b0});
    for (int i = 0; i < eff; i++) exp_q.push_back('{d[i], S, 1'b0});
    if (pm == 1 || pm == 2) begin
      p = (pm == 2);
      for (int i = 0; i < eff; i++) p = p ^ d[i];
      exp_q.push_back('{p, S, 1'b0});
    end
    sb = (sm == 1) ? (3 * S) / 2 : (sm == 2) ? 2 * S : S;
    exp_q.push_back('{1'b1, sb, 1'b1});
  endtask

  task automatic send(input string name, input logic [7:0] d, input int nb,
                      input int pm, input int sm, input bit now);
    if (!now) @(negedge clk);
    d_in      = d;
    dbits     = nb[3:0];
    par_mode  = pm[1:0];
    stop_mode = sm[1:0];
    start     = 1'b1;
    push_frame(d, nb, pm, sm);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s start_bit: tx=%b busy=%b, want tx=0 busy=1", name, tx, busy);
    end
  endtask

  // Samples from the negedge right after acceptance until done_tick; returns on that negedge.
  task automatic check_frame(input string name, input int inject_at);
    logic obs[$];
    bit   busy_ok;
    bit   done_seen;
    seg_t sg;
    int   pos;
    int   bad;
    int   k;
    busy_ok   = 1'b1;
    done_seen = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n == inject_at) begin
        d_in      = ~d_in;
        dbits     = 4'd3;
        par_mode  = 2'b01;
        stop_mode = 2'b10;
        start     = 1'b1;
      end
      if (n == inject_at + 1) start = 1'b0;
      if (done_tick === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (s_tick) obs.push_back(tx);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL %s done_timeout: done_tick not seen within 4000 clks", name);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s busy_gap: busy dropped before done_tick, want high throughout", name);
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL %s at_done: busy=%b tx=%b, want busy=0 tx=1", name, busy, tx);
    end
    pos = 0;
    k   = 0;
    while (exp_q.size() > 0) begin
      sg  = exp_q.pop_front();
      bad = 0;
      for (int j = 0; j < sg.len; j++) begin
        if (pos + j >= obs.size()) bad++;
        else if (obs[pos + j] !== sg.val) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s bit%0d: %0d of %0d ticks differ from required level %b",
                 name, k, bad, sg.len, sg.val);
      end
      pos += sg.len;
      k++;
      if (sg.last) break;
    end
    checks++;
    if (obs.size() != pos) begin
      failures++;
      $display("FAIL %s frame_len: got %0d s_ticks, want %0d", name, obs.size(), pos);
    end
  endtask

  task automatic check_done_pulse(input string name);
    @(negedge clk);
    checks++;
    if (done_tick !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: done_tick=%b one clk later, want 0", name, done_tick);
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    bit ok;
    ok = 1'b1;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done_tick !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s idle: line left idle (tx=%b busy=%b done=%b), want tx=1 busy=0",
               name, tx, busy, done_tick);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; d_in = '0; dbits = '0; par_mode = '0; stop_mode = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done_tick !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_tick); end
    reset_n = 1'b1;
    check_idle("post_reset", 10);
  endtask

  task automatic test_8n1();
    send("8n1", 8'h55, 8, 0, 0, 1'b0);
    check_frame("8n1", -1);
    check_done_pulse("8n1");
  endtask

  task automatic test_even7();
    send("even7", 8'h41, 7, 1, 0, 1'b0);
    check_frame("even7", -1);
  endtask

  task automatic test_odd_two_stop();
    send("odd2stop", 8'hFF, 8, 2, 2, 1'b0);
    check_frame("odd2stop", -1);
  endtask

  task automatic test_five_bit_onehalf();
    send("5bit1p5", 8'h13, 5, 0, 1, 1'b0);
    check_frame("5bit1p5", -1);
  endtask

  task automatic test_dbits_zero();
    send("dbits0", 8'hA5, 0, 1, 3, 1'b0);
    check_frame("dbits0", -1);
  endtask

  task automatic test_start_while_busy();
    send("busy_start", 8'h96, 8, 0, 0, 1'b0);
    check_frame("busy_start", 80);
    check_idle("no_requeue", 200);
  endtask

  task automatic test_back_to_back();
    send("b2b_a", 8'h3C, 8, 1, 0, 1'b0);
    check_frame("b2b_a", -1);
    send("b2b_b", 8'hC5, 6, 2, 2, 1'b1);
    check_frame("b2b_b", -1);
    check_done_pulse("b2b_b");
  endtask

  task automatic test_reset_mid_frame();
    send("rst_mid", 8'h00, 8, 0, 0, 1'b0);
    repeat (70) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid pre: busy=%b tx=%b, want busy=1 tx=0", busy, tx);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid async: tx=%b busy=%b before clk edge, want tx=1 busy=0", tx, busy);
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    check_idle("rst_release", 150);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_even7();
    test_odd_two_stop();
    test_five_bit_onehalf();
    test_dbits_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
